// File: rtl/y86_stage_reg_pkg.sv
// Shared Y86 constants: status codes, instruction codes, register IDs and the
// default field widths used by the pipeline stage registers.
package y86_stage_reg_pkg;

    localparam int DEF_WORD_W  = 64;
    localparam int DEF_ICODE_W = 4;
    localparam int DEF_REG_W   = 4;
    localparam int DEF_STAT_W  = 3;

    typedef enum logic [2:0] {
        SAOK = 3'h1,
        SHLT = 3'h2,
        SADR = 3'h3,
        SINS = 3'h4
    } stat_e;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

endpackage

// File: rtl/y86_stage_reg_if.sv
// Bundle between pipeline control/upstream stage (master) and a stage register (slave).
interface y86_stage_reg_if
    import y86_stage_reg_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int ICODE_W = DEF_ICODE_W,
    parameter int REG_W   = DEF_REG_W,
    parameter int STAT_W  = DEF_STAT_W
);
    logic               stall;
    logic               bubble;
    logic [STAT_W-1:0]  in_stat;
    logic [ICODE_W-1:0] in_icode;
    logic               in_cnd;
    logic [WORD_W-1:0]  in_valE;
    logic [WORD_W-1:0]  in_valA;
    logic [REG_W-1:0]   in_dstE;
    logic [REG_W-1:0]   in_dstM;

    logic [STAT_W-1:0]  out_stat;
    logic [ICODE_W-1:0] out_icode;
    logic               out_cnd;
    logic [WORD_W-1:0]  out_valE;
    logic [WORD_W-1:0]  out_valA;
    logic [REG_W-1:0]   out_dstE;
    logic [REG_W-1:0]   out_dstM;
    logic               out_valid;
    logic               ctl_err;

    modport master (
        output stall, bubble, in_stat, in_icode, in_cnd, in_valE, in_valA, in_dstE, in_dstM,
        input  out_stat, out_icode, out_cnd, out_valE, out_valA, out_dstE, out_dstM,
               out_valid, ctl_err
    );

    modport slave (
        input  stall, bubble, in_stat, in_icode, in_cnd, in_valE, in_valA, in_dstE, in_dstM,
        output out_stat, out_icode, out_cnd, out_valE, out_valA, out_dstE, out_dstM,
               out_valid, ctl_err
    );

endinterface

// File: rtl/y86_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; used for stage-register event statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/y86_stage_reg.sv
// Generic Y86 pipeline stage register with stall/bubble control and an illegal-control flag.
// Optional macro Y86_STAGE_PERF_EN adds saturating bubble/stall/load event counters.
module y86_stage_reg
    import y86_stage_reg_pkg::*;
#(
    parameter int                 WORD_W    = DEF_WORD_W,
    parameter int                 ICODE_W   = DEF_ICODE_W,
    parameter int                 REG_W     = DEF_REG_W,
    parameter int                 STAT_W    = DEF_STAT_W,
    parameter logic [ICODE_W-1:0] NOP_ICODE = ICODE_W'(INOP),
    parameter logic [STAT_W-1:0]  BUB_STAT  = STAT_W'(SAOK),
    parameter logic [REG_W-1:0]   RNONE     = REG_W'(y86_stage_reg_pkg::RNONE)
) (
    input  logic            clk,
    input  logic            rst,
    y86_stage_reg_if.slave  bus
`ifdef Y86_STAGE_PERF_EN
    ,
    output logic [31:0]     perf_bubbles,
    output logic [31:0]     perf_stalls,
    output logic [31:0]     perf_loads
`endif
);

    logic [STAT_W-1:0]  stat_q;
    logic [ICODE_W-1:0] icode_q;
    logic               cnd_q;
    logic [WORD_W-1:0]  val_e_q;
    logic [WORD_W-1:0]  val_a_q;
    logic [REG_W-1:0]   dst_e_q;
    logic [REG_W-1:0]   dst_m_q;
    logic               valid_q;
    logic               err_q;

    // Reset and bubble share the NOP bundle; a stall simply leaves every field untouched.
    always_ff @(posedge clk) begin
        if (rst || bus.bubble) begin
            stat_q  <= BUB_STAT;
            icode_q <= NOP_ICODE;
            cnd_q   <= 1'b0;
            val_e_q <= '0;
            val_a_q <= '0;
            dst_e_q <= RNONE;
            dst_m_q <= RNONE;
            valid_q <= 1'b0;
        end else if (!bus.stall) begin
            stat_q  <= bus.in_stat;
            icode_q <= bus.in_icode;
            cnd_q   <= bus.in_cnd;
            val_e_q <= bus.in_valE;
            val_a_q <= bus.in_valA;
            dst_e_q <= bus.in_dstE;
            dst_m_q <= bus.in_dstM;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.stall && bus.bubble;
        end
    end

    assign bus.out_stat  = stat_q;
    assign bus.out_icode = icode_q;
    assign bus.out_cnd   = cnd_q;
    assign bus.out_valE  = val_e_q;
    assign bus.out_valA  = val_a_q;
    assign bus.out_dstE  = dst_e_q;
    assign bus.out_dstM  = dst_m_q;
    assign bus.out_valid = valid_q;
    assign bus.ctl_err   = err_q;

`ifdef Y86_STAGE_PERF_EN
    logic do_bubble;
    logic do_stall;
    logic do_load;

    // A stall+bubble edge is accounted as a bubble, matching what the payload actually did.
    assign do_bubble = !rst && bus.bubble;
    assign do_stall  = !rst && bus.stall && !bus.bubble;
    assign do_load   = !rst && !bus.stall && !bus.bubble;

    sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_bubble),
        .count (perf_bubbles)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_stall),
        .count (perf_stalls)
    );

    sat_counter #(.WIDTH(32)) u_load_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (do_load),
        .count (perf_loads)
    );
`endif

endmodule

// File: tb/tb_y86_stage_reg.sv
// Self-checking bench for y86_stage_reg: vector table plus scoreboard-checked hand sequences.
// Build with Y86_STAGE_PERF_EN defined to also exercise the event counters.
module tb_y86_stage_reg;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } bundle_t;

    typedef struct {
        logic    rst;
        logic    stall;
        logic    bubble;
        bundle_t in_b;
        bundle_t exp_b;
        logic    exp_valid;
        logic    exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    vec_t    sb[$];
    vec_t    vecs[16];
    bundle_t nop_b;
    bundle_t b1, b2, b3, b4, b5;
    bundle_t model_b;
    logic    model_valid;

    y86_stage_reg_if bus ();

`ifdef Y86_STAGE_PERF_EN
    logic [31:0] perf_bubbles;
    logic [31:0] perf_stalls;
    logic [31:0] perf_loads;
`endif

    y86_stage_reg dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef Y86_STAGE_PERF_EN
        ,
        .perf_bubbles (perf_bubbles),
        .perf_stalls  (perf_stalls),
        .perf_loads   (perf_loads)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.stat  = 3'($urandom_range(0, 7));
        b.icode = 4'($urandom_range(0, 15));
        b.cnd   = 1'($urandom_range(0, 1));
        b.valE  = {$urandom, $urandom};
        b.valA  = {$urandom, $urandom};
        b.dstE  = 4'($urandom_range(0, 15));
        b.dstM  = 4'($urandom_range(0, 15));
        return b;
    endfunction

    // Reference behaviour: rst > bubble > stall > load, relative to the modelled register contents.
    function automatic vec_t make_vec(input logic r, input logic s, input logic b, input bundle_t in_b);
        vec_t v;
        v.rst    = r;
        v.stall  = s;
        v.bubble = b;
        v.in_b   = in_b;
        if (r || b) begin
            v.exp_b     = nop_b;
            v.exp_valid = 1'b0;
        end else if (s) begin
            v.exp_b     = model_b;
            v.exp_valid = model_valid;
        end else begin
            v.exp_b     = in_b;
            v.exp_valid = 1'b1;
        end
        v.exp_err = !r && s && b;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        bus.stall    = v.stall;
        bus.bubble   = v.bubble;
        bus.in_stat  = v.in_b.stat;
        bus.in_icode = v.in_b.icode;
        bus.in_cnd   = v.in_b.cnd;
        bus.in_valE  = v.in_b.valE;
        bus.in_valA  = v.in_b.valA;
        bus.in_dstE  = v.in_b.dstE;
        bus.in_dstM  = v.in_b.dstM;
        sb.push_back(v);
        model_b     = v.exp_b;
        model_valid = v.exp_valid;
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected one entry", tag);
            return;
        end
        e = sb.pop_front();
        check_field({tag, " stat"},  64'(bus.out_stat),  64'(e.exp_b.stat));
        check_field({tag, " icode"}, 64'(bus.out_icode), 64'(e.exp_b.icode));
        check_field({tag, " cnd"},   64'(bus.out_cnd),   64'(e.exp_b.cnd));
        check_field({tag, " valE"},  bus.out_valE,       e.exp_b.valE);
        check_field({tag, " valA"},  bus.out_valA,       e.exp_b.valA);
        check_field({tag, " dstE"},  64'(bus.out_dstE),  64'(e.exp_b.dstE));
        check_field({tag, " dstM"},  64'(bus.out_dstM),  64'(e.exp_b.dstM));
        check_field({tag, " valid"}, 64'(bus.out_valid), 64'(e.exp_valid));
        check_field({tag, " err"},   64'(bus.ctl_err),   64'(e.exp_err));
    endtask

    task automatic cycle(input vec_t v, input string tag);
        applyStimulus(v);
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        nop_b = '{3'h1, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF};
        b1    = '{3'h1, 4'h6, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_1234, 4'h3, 4'hF};
        b2    = '{3'h3, 4'h5, 1'b0, 64'hA5A5_A5A5_5A5A_5A5A, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'h7};
        b3    = '{3'h1, 4'h2, 1'b1, 64'h2, 64'h3, 4'h4, 4'h5};
        b4    = '{3'h4, 4'h7, 1'b0, 64'h8000_0000_0000_0000, 64'h1, 4'h0, 4'hE};
        b5    = '{3'h2, 4'h2, 1'b1, 64'h1111, 64'h2222, 4'h1, 4'h2};

        //              rst   stall bubble in   expected  valid err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, b5, nop_b, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, b1, nop_b, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, b1, b1,    1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, b2, b2,    1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, b5, b2,    1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, b3, b2,    1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, b3, nop_b, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, b3, b3,    1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, b4, nop_b, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, b4, b4,    1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, b1, b4,    1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, b1, nop_b, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, b2, nop_b, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, b2, nop_b, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, b2, nop_b, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, b2, b2,    1'b1, 1'b0};

        model_b     = nop_b;
        model_valid = 1'b0;
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.bubble   = 1'b0;
        bus.in_stat  = '0;
        bus.in_icode = '0;
        bus.in_cnd   = 1'b0;
        bus.in_valE  = '0;
        bus.in_valA  = '0;
        bus.in_dstE  = '0;
        bus.in_dstM  = '0;

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // Multi-cycle stall: the loaded bundle must survive changing inputs.
        begin
            bundle_t x;
            x = rand_bundle();
            cycle(make_vec(1'b0, 1'b0, 1'b0, x), "hold load");
            for (int i = 0; i < 3; i++) begin
                cycle(make_vec(1'b0, 1'b1, 1'b0, rand_bundle()), $sformatf("hold stall%0d", i));
            end
        end

        // ctl_err must pulse for exactly one cycle after a stall+bubble edge.
        cycle(make_vec(1'b0, 1'b0, 1'b0, b3), "err pre");
        cycle(make_vec(1'b0, 1'b1, 1'b1, b4), "err both");
        cycle(make_vec(1'b0, 1'b0, 1'b0, b4), "err after");
        cycle(make_vec(1'b0, 1'b1, 1'b0, b1), "err stall");

        for (int i = 0; i < 24; i++) begin
            cycle(make_vec(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 4) == 0), rand_bundle()),
                  $sformatf("rand%0d", i));
        end

`ifdef Y86_STAGE_PERF_EN
        cycle(make_vec(1'b1, 1'b0, 1'b0, b1), "perf rst");
        check_field("perf bubbles after rst", 64'(perf_bubbles), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(make_vec(1'b0, 1'b0, 1'b0, rand_bundle()), $sformatf("perf load%0d", i));
        end
        cycle(make_vec(1'b0, 1'b1, 1'b0, b2), "perf stall0");
        cycle(make_vec(1'b0, 1'b1, 1'b0, b3), "perf stall1");
        cycle(make_vec(1'b0, 1'b0, 1'b1, b4), "perf bubble");
        check_field("perf loads",   64'(perf_loads),   64'd5);
        check_field("perf stalls",  64'(perf_stalls),  64'd2);
        check_field("perf bubbles", 64'(perf_bubbles), 64'd1);
        cycle(make_vec(1'b0, 1'b1, 1'b1, b4), "perf both");
        check_field("perf both bubbles", 64'(perf_bubbles), 64'd2);
        check_field("perf both stalls",  64'(perf_stalls),  64'd2);
        cycle(make_vec(1'b1, 1'b1, 1'b0, b1), "perf clear");
        check_field("perf clr loads",   64'(perf_loads),   64'd0);
        check_field("perf clr stalls",  64'(perf_stalls),  64'd0);
        check_field("perf clr bubbles", 64'(perf_bubbles), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
